// File: rtl/bcd_adder_core_if.sv
// Operand/result bundle for the packed-BCD adder.
// master drives the operands; slave is the adder side.
interface bcd_adder_core_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic [N-1:0] Addend;
  logic [N-1:0] Augend;
  logic         Carry_in;
  logic [N-1:0] Sum;
  logic         Carry_out;
  logic         out_valid;
  logic         in_err;

  modport master (
    output in_valid, Addend, Augend, Carry_in,
    input  Sum, Carry_out, out_valid, in_err
  );

  modport slave (
    input  in_valid, Addend, Augend, Carry_in,
    output Sum, Carry_out, out_valid, in_err
  );
endinterface

// File: rtl/bcd_adder_core.sv
// Packed-BCD ripple adder with registered outputs; 1-cycle latency, one result per cycle.
// No backpressure: every in_valid is accepted; results hold while in_valid is low.
module bcd_adder_core #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_adder_core_if.slave  bus
);
  localparam int DIGITS = N / 4;

  logic [DIGITS:0]  carry_chain;
  logic [DIGITS-1:0] nib_err;
  logic [N-1:0]     sum_d;
  logic [N-1:0]     sum_q;
  logic             carry_d;
  logic             carry_q;
  logic             err_d;
  logic             err_q;
  logic             vld_q;

  assign carry_chain[0] = bus.Carry_in;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] s_bin;
    logic [4:0] s_adj;

    assign a     = bus.Addend[4*k +: 4];
    assign b     = bus.Augend[4*k +: 4];
    assign s_bin = {1'b0, a} + {1'b0, b} + {4'd0, carry_chain[k]};
    assign s_adj = s_bin + 5'd6;
    // Correction is applied even to non-BCD nibbles so the result stays deterministic.
    assign carry_chain[k+1]  = (s_bin > 5'd9);
    assign sum_d[4*k +: 4]   = carry_chain[k+1] ? s_adj[3:0] : s_bin[3:0];
    assign nib_err[k]        = (a > 4'd9) || (b > 4'd9);
  end

  assign carry_d = carry_chain[DIGITS];
  assign err_d   = |nib_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        err_q   <= err_d;
      end
    end
  end

  assign bus.Sum       = sum_q;
  assign bus.Carry_out = carry_q;
  assign bus.in_err    = err_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_bcd_adder_core.sv
// Randomised and directed checks of bcd_adder_core at N=4 and N=8 against a decimal reference.
module tb_bcd_adder_core;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [7:0] last_sum;
  logic       last_carry;

  bcd_adder_core_if #(.N(4)) if4 ();
  bcd_adder_core_if #(.N(8)) if8 ();

  bcd_adder_core #(.N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  bcd_adder_core #(.N(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Valid operands are summed as decimal numbers; non-BCD operands follow the per-digit +6 rule.
  task automatic ref_bcd_add(input int digits, input logic [7:0] a, input logic [7:0] b,
                             input logic cin, output logic [7:0] s, output logic c,
                             output logic e);
    int va, vb, tot, p, cc, d;
    s = '0; c = 1'b0; e = 1'b0; va = 0; vb = 0; p = 1;
    for (int k = 0; k < digits; k++) begin
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) e = 1'b1;
      va += int'(a[4*k +: 4]) * p;
      vb += int'(b[4*k +: 4]) * p;
      p  *= 10;
    end
    if (!e) begin
      tot = va + vb + int'(cin);
      c   = (tot >= p);
      tot = tot % p;
      for (int k = 0; k < digits; k++) begin
        s[4*k +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      cc = int'(cin);
      for (int k = 0; k < digits; k++) begin
        d = int'(a[4*k +: 4]) + int'(b[4*k +: 4]) + cc;
        if (d > 9) begin
          d  = d + 6;
          cc = 1;
        end else begin
          cc = 0;
        end
        s[4*k +: 4] = 4'(d % 16);
      end
      c = cc[0];
    end
  endtask

  task automatic apply(input bit wide, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input string tag);
    logic [7:0] es;
    logic       ec;
    logic       ee;
    @(negedge clk);
    if (wide) begin
      if8.in_valid = 1'b1; if8.Addend = a; if8.Augend = b; if8.Carry_in = cin;
      if4.in_valid = 1'b0;
    end else begin
      if4.in_valid = 1'b1; if4.Addend = a[3:0]; if4.Augend = b[3:0]; if4.Carry_in = cin;
      if8.in_valid = 1'b0;
    end
    ref_bcd_add(wide ? 2 : 1, a, b, cin, es, ec, ee);
    @(posedge clk);
    #1;
    if (wide) begin
      check({tag, ".vld"}, 32'(if8.out_valid), 32'd1);
      check({tag, ".sum"}, 32'(if8.Sum), 32'(es));
      check({tag, ".cout"}, 32'(if8.Carry_out), 32'(ec));
      check({tag, ".err"}, 32'(if8.in_err), 32'(ee));
    end else begin
      check({tag, ".vld"}, 32'(if4.out_valid), 32'd1);
      check({tag, ".sum"}, 32'(if4.Sum), 32'(es[3:0]));
      check({tag, ".cout"}, 32'(if4.Carry_out), 32'(ec));
      check({tag, ".err"}, 32'(if4.in_err), 32'(ee));
    end
    last_sum   = es;
    last_carry = ec;
  endtask

  task automatic idle_check(input bit wide, input string tag);
    @(negedge clk);
    if4.in_valid = 1'b0;
    if8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    if (wide) begin
      check({tag, ".vld"}, 32'(if8.out_valid), 32'd0);
      check({tag, ".hold_sum"}, 32'(if8.Sum), 32'(last_sum));
      check({tag, ".hold_cout"}, 32'(if8.Carry_out), 32'(last_carry));
    end else begin
      check({tag, ".vld"}, 32'(if4.out_valid), 32'd0);
      check({tag, ".hold_sum"}, 32'(if4.Sum), 32'(last_sum[3:0]));
      check({tag, ".hold_cout"}, 32'(if4.Carry_out), 32'(last_carry));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".sum4"}, 32'(if4.Sum), 32'd0);
    check({tag, ".cout4"}, 32'(if4.Carry_out), 32'd0);
    check({tag, ".vld4"}, 32'(if4.out_valid), 32'd0);
    check({tag, ".err4"}, 32'(if4.in_err), 32'd0);
    check({tag, ".sum8"}, 32'(if8.Sum), 32'd0);
    check({tag, ".vld8"}, 32'(if8.out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    if4.in_valid = 1'b0; if4.Addend = '0; if4.Augend = '0; if4.Carry_in = 1'b0;
    if8.in_valid = 1'b0; if8.Addend = '0; if8.Augend = '0; if8.Carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle discards a loaded result.
    apply(1'b0, 8'h07, 8'h05, 1'b0, "pre_rst_7p5");
    if4.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("post_rst_idle");

    apply(1'b0, 8'h00, 8'h00, 1'b0, "add_0p0");
    idle_check(1'b0, "one_cycle_vld");
    apply(1'b0, 8'h05, 8'h04, 1'b0, "add_5p4");
    apply(1'b0, 8'h07, 8'h05, 1'b0, "add_7p5");
    apply(1'b0, 8'h04, 8'h06, 1'b0, "add_4p6");
    apply(1'b0, 8'h09, 8'h09, 1'b1, "add_9p9p1");
    apply(1'b0, 8'h00, 8'h09, 1'b1, "add_0p9p1");
    apply(1'b0, 8'h0C, 8'h03, 1'b0, "bad_12p3");
    check("bad_12p3.sum_const", 32'(if4.Sum), 32'd5);
    apply(1'b0, 8'h03, 8'h03, 1'b0, "add_3p3");
    check("add_3p3.sum_const", 32'(if4.Sum), 32'd6);

    apply(1'b1, 8'h99, 8'h01, 1'b0, "w_99p01");
    check("w_99p01.sum_const", 32'(if8.Sum), 32'h00);
    apply(1'b1, 8'h45, 8'h38, 1'b1, "w_45p38p1");
    check("w_45p38p1.sum_const", 32'(if8.Sum), 32'h84);
    idle_check(1'b1, "w_idle");

    // Back-to-back digit pairs 0..7, then one idle cycle must hold the last result.
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(7, 0));
      rb = 8'($urandom_range(7, 0));
      apply(1'b0, ra, rb, 1'b0, $sformatf("b2b%0d", i));
    end
    idle_check(1'b0, "b2b_idle");

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(9, 0));
      rb = 8'($urandom_range(9, 0));
      rc = 1'($urandom_range(1, 0));
      apply(1'b0, ra, rb, rc, $sformatf("r4_%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(15, 0));
      rb = 8'($urandom_range(15, 0));
      rc = 1'($urandom_range(1, 0));
      apply(1'b0, ra, rb, rc, $sformatf("x4_%0d", i));
    end
    for (int i = 0; i < 24; i++) begin
      ra = {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
      rb = {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
      rc = 1'($urandom_range(1, 0));
      apply(1'b1, ra, rb, rc, $sformatf("r8_%0d", i));
    end
    idle_check(1'b1, "r8_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_adder_core.md
Name: bcd_adder_core

Overview:
Registered, parameterisable packed-BCD adder. Adds two N-bit packed-BCD operands plus a carry-in through a ripple chain of decimal-corrected digit adders. Produces an N-bit BCD sum and a decimal carry-out one clock after a valid input. Used as the decimal arithmetic leaf in datapaths; default configuration is a single BCD digit.

Parameters:
N, 4, operand/sum width in bits; must be a positive multiple of 4; DIGITS = N/4 (N=4 → 1 digit).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  qualifies Addend/Augend/Carry_in this cycle
Addend  input  N  packed-BCD operand A, digit 0 in bits [3:0]
Augend  input  N  packed-BCD operand B, same packing
Carry_in  input  1  decimal carry into digit 0
Sum  output  N  registered packed-BCD sum
Carry_out  output  1  registered decimal carry out of the top digit
out_valid  output  1  registered; high for one cycle per accepted input
in_err  output  1  registered; any input digit of the accepted operands > 9

Behaviour:
- Clock: one clock. Reset: asynchronous, active-low, no synchronous reset.
- Reset (rst_n=0): Sum=0, Carry_out=0, out_valid=0, in_err=0, immediately and independent of clk. Reset mid-operation discards any in-flight result; first valid result after release needs a fresh in_valid.
- Digit k adder: inputs a=Addend[4k+3:4k], b=Augend[4k+3:4k], c=carry from digit k-1 (Carry_in for k=0).
  - s = a+b+c as 5-bit binary, range 0..31.
  - s ≤ 9: digit sum = s[3:0], carry = 0.
  - s > 9: digit sum = (s+6)[3:0], carry = 1.
- Carries ripple combinationally across all DIGITS in the same cycle. Carry_out = carry of digit DIGITS-1.
- Latency: exactly 1 cycle. Sum, Carry_out, in_err and out_valid are updated at the rising edge where in_valid=1.
- in_valid=0 at an edge: out_valid←0; Sum, Carry_out and in_err hold their previous values.
- Back-to-back in_valid accepted every cycle (throughput 1/cycle). No backpressure.
- Invalid BCD input (any nibble of Addend or Augend in 10..15): in_err←1 with that result. The same correction rule still applies, so Sum/Carry_out are deterministic but not meaningful BCD. Carry_in is treated as 1 bit; no error for it.
- Full-range valid case: max 9+9+1=19 → digit 9, carry 1. Sum is always valid BCD when in_err=0.
- No internal state beyond output registers; no X propagation from reset values.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle after a result 7+5 was loaded → Sum=0, Carry_out=0, out_valid=0, in_err=0 immediately. After release with in_valid=0, outputs stay 0.
- No-correction adds (N=4): 0+0+0 → Sum=0, Carry_out=0; 5+4+0 → Sum=9, Carry_out=0. out_valid=1 exactly one cycle after each in_valid.
- Correction adds (N=4): 7+5+0 → Sum=2, Carry_out=1; 4+6+0 → Sum=0, Carry_out=1; 9+9+1 → Sum=9, Carry_out=1; 0+9+1 → Sum=0, Carry_out=1.
- Invalid digit (N=4): 12+3+0 → in_err=1, Sum=5, Carry_out=1. Next valid input 3+3+0 → in_err=0, Sum=6.
- Multi-digit ripple (N=8): 0x99+0x01+0 → Sum=0x00, Carry_out=1; 0x45+0x38+1 → Sum=0x84, Carry_out=0.
- Hold/throughput: 8 random valid digit pairs (0..7) on consecutive cycles. Each output matches the decimal reference one cycle later. A following in_valid=0 cycle → out_valid=0 with Sum and Carry_out held.
